foreground_tile_plane: RTL and testbench
========================================

Name: foreground_tile_plane

Overview:
Parametrised tile-based foreground plane. Replaces the fixed-colour foreground source with a tile-mapped, scrollable, palette-driven layer. For each active pixel it reads a tile-map entry and a pattern row from external synchronous VRAM, then looks the colour up in an internal palette. It outputs a 24-bit RGB pixel with an opacity flag to the plane mixer.

Parameters:
X_W, 11, pixel X coordinate width
Y_W, 10, pixel Y coordinate width
TILE_LOG2, 3, tile edge = 2^TILE_LOG2 px (8)
MAP_COLS_LOG2, 7, map columns = 2^MAP_COLS_LOG2 (128)
MAP_ROWS_LOG2, 6, map rows = 2^MAP_ROWS_LOG2 (64)
BPP, 4, bits per pixel in the pattern; palette bank = 2^BPP entries
TILE_IDX_W, 10, tile index width
DEFAULT_COLOR, 24'h3F5F7F, colour driven for transparent active pixels

Ports:
I_pxl_clk  in  1  pixel clock
I_rst_n  in  1  asynchronous active-low reset
I_de  in  1  display enable for I_x/I_y
I_vs  in  1  vertical sync, active high
I_x  in  X_W  current pixel X
I_y  in  Y_W  current pixel Y
I_scroll_x  in  MAP_COLS_LOG2+TILE_LOG2  requested X scroll
I_scroll_y  in  MAP_ROWS_LOG2+TILE_LOG2  requested Y scroll
O_map_addr  out  MAP_COLS_LOG2+MAP_ROWS_LOG2  tile-map RAM address, {row,col}
I_map_data  in  16  map entry: [TILE_IDX_W-1:0] tile, [13:10] palette bank, [14] hflip, [15] blink
O_pat_addr  out  TILE_IDX_W+TILE_LOG2  pattern RAM address, {tile,fine_y}
I_pat_data  in  BPP<<TILE_LOG2  one pattern row; pixel 0 in bits [BPP-1:0]
I_pal_we  in  1  palette write strobe
I_pal_addr  in  4+BPP  palette write address, {bank,index}
I_pal_data  in  24  palette write data
O_pixel  out  24  RGB out
O_opaque  out  1  pixel non-transparent
O_de  out  1  I_de delayed to match O_pixel

Behaviour:
- Reset (asynchronous): O_pixel=0, O_opaque=0, O_de=0, O_map_addr=0, O_pat_addr=0, scroll shadows=0, all palette entries=0, pipeline valid bits cleared.
- External RAMs are synchronous. Data for an address registered at edge n is valid on I_*_data during cycle n+1 and is sampled at edge n+1.
- Pipeline, fixed latency of 4 edges from I_x/I_y/I_de to O_pixel/O_de:
  - E1: ex=(I_x+sx) mod 2^(MAP_COLS_LOG2+TILE_LOG2); ey=(I_y+sy) mod 2^(MAP_ROWS_LOG2+TILE_LOG2). Register O_map_addr={ey_hi,ex_hi}. Carry fine_x, fine_y and de.
  - E2: sample I_map_data. Register O_pat_addr={tile,fine_y}. Carry bank, hflip, blink, fine_x and de.
  - E3: sample I_pat_data. px = hflip ? (2^TILE_LOG2-1-fine_x) : fine_x. ci = pixel px. Register pal_idx={bank,ci}.
  - E4: !de -> O_pixel=0, O_opaque=0. de&&ci==0 -> O_pixel=DEFAULT_COLOR, O_opaque=0. Otherwise O_pixel=palette[pal_idx], O_opaque=1. O_de=de.
- Scroll: sx/sy are shadow registers loaded from I_scroll_x/I_scroll_y on the edge after an I_vs rising edge is detected (I_vs registered once). Changes mid-frame have no effect until the next frame.
- Wrap-around: map coordinates wrap modulo map size. Scroll plus coordinate overflow is discarded.
- Palette: one write per cycle. It is visible to lookups on edges after the write edge. A same-edge read and write of the same entry returns the old value.
- Reset mid-frame: pipeline flushed. O_de stays 0 until 4 edges after the first I_de=1 following reset release.
- Pipeline runs continuously. No stall. RAM addresses are driven during blanking too (don't-care data).

Optional Feature:
FOREGROUND_BLINK_EN
- Defined: a 6-bit frame counter increments on each detected I_vs rise (reset 0). If map bit 15 is set and counter[5]=1, the pixel is forced transparent (DEFAULT_COLOR, O_opaque=0). Result: 32 frames shown, 32 frames hidden.
- Undefined: no counter. Bit 15 is ignored.

Test Plan:
- Reset held, then released, no I_de -> O_pixel=0, O_opaque=0, O_de=0. Palette reads back 0 (ci≠0 pixels show 24'h000000).
- Palette[{2,5}]=24'hFF0000. Map entry (0,0)={bank 2,tile 3}. Pattern {3,0}=32'h00000050. x=1,y=0,de=1 -> after 4 edges O_pixel=FF0000, O_opaque=1. x=0 -> 3F5F7F, O_opaque=0.
- Same data with hflip=1 and x=6 -> FF0000. With x=1 -> DEFAULT_COLOR.
- I_scroll_x=1020 latched at vs -> x=5 reads map column 0 fine_x 1 (wrap). Changing I_scroll_x mid-frame -> no change until next vs.
- Palette write to {2,5} on the same edge that E4 reads it -> old colour output. Next pixel -> new colour.
- FOREGROUND_BLINK_EN, blink bit set: frames 0-31 -> colour shown; frames 32-63 -> DEFAULT_COLOR, O_opaque=0. Without the macro -> always shown.

Source files
------------

// File: rtl/foreground_tile_plane.sv
// Tile-mapped, scrollable, palette-driven foreground plane; optional FOREGROUND_BLINK_EN adds map-bit-15 blinking.
// Latency: fixed 4 I_pxl_clk edges from I_x/I_y/I_de to O_pixel/O_opaque/O_de.
// Backpressure: none; free-running pipeline, external VRAMs must answer one cycle after each address.
module foreground_tile_plane #(
    parameter int          X_W           = 11,
    parameter int          Y_W           = 10,
    parameter int          TILE_LOG2     = 3,
    parameter int          MAP_COLS_LOG2 = 7,
    parameter int          MAP_ROWS_LOG2 = 6,
    parameter int          BPP           = 4,
    parameter int          TILE_IDX_W    = 10,
    parameter logic [23:0] DEFAULT_COLOR = 24'h3F5F7F
) (
    input  logic                                   I_pxl_clk,
    input  logic                                   I_rst_n,
    input  logic                                   I_de,
    input  logic                                   I_vs,
    input  logic [X_W-1:0]                         I_x,
    input  logic [Y_W-1:0]                         I_y,
    input  logic [MAP_COLS_LOG2+TILE_LOG2-1:0]     I_scroll_x,
    input  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]     I_scroll_y,
    output logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0] O_map_addr,
    input  logic [15:0]                            I_map_data,
    output logic [TILE_IDX_W+TILE_LOG2-1:0]        O_pat_addr,
    input  logic [(BPP<<TILE_LOG2)-1:0]            I_pat_data,
    input  logic                                   I_pal_we,
    input  logic [4+BPP-1:0]                       I_pal_addr,
    input  logic [23:0]                            I_pal_data,
    output logic [23:0]                            O_pixel,
    output logic                                   O_opaque,
    output logic                                   O_de
);
    localparam int EX_W   = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int EY_W   = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int PAL_AW = 4 + BPP;
    localparam int PAL_N  = 1 << PAL_AW;

    typedef struct packed {
        logic                 de;
        logic [TILE_LOG2-1:0] fx;
        logic [TILE_LOG2-1:0] fy;
    } s1_t;

    typedef struct packed {
        logic                 de;
        logic [TILE_LOG2-1:0] fx;
        logic [3:0]           bank;
        logic                 hflip;
        logic                 hide;
    } s2_t;

    typedef struct packed {
        logic              de;
        logic              transp;
        logic [PAL_AW-1:0] idx;
    } s3_t;

    logic            vs_q;
    logic            vs_rise;
    logic [EX_W-1:0] sx;
    logic [EY_W-1:0] sy;
    logic [EX_W-1:0] ex;
    logic [EY_W-1:0] ey;
    s1_t             s1_q;
    s2_t             s2_q;
    s3_t             s3_q;
    logic            hide_now;
    logic [TILE_LOG2-1:0] px;
    logic [BPP-1:0]  ci;
    logic [23:0]     pal [PAL_N];
    logic            unused_bits;

    assign vs_rise = I_vs & ~vs_q;

    // Scroll is frame-synchronous: shadows only move at the start of a frame.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_q <= 1'b0;
            sx   <= '0;
            sy   <= '0;
        end else begin
            vs_q <= I_vs;
            if (vs_rise) begin
                sx <= I_scroll_x;
                sy <= I_scroll_y;
            end
        end
    end

`ifdef FOREGROUND_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_cnt <= '0;
        end else if (vs_rise) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign hide_now = I_map_data[15] & frame_cnt[5];
`else
    assign hide_now = 1'b0;
`endif

    assign ex = EX_W'(I_x) + sx;
    assign ey = EY_W'(I_y) + sy;

    // Horizontal flip mirrors the column: (2^TILE_LOG2-1-fx) is the bitwise inverse.
    assign px = s2_q.hflip ? ~s2_q.fx : s2_q.fx;
    assign ci = I_pat_data[px*BPP +: BPP];

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_map_addr <= '0;
            O_pat_addr <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
        end else begin
            O_map_addr  <= {ey[EY_W-1:TILE_LOG2], ex[EX_W-1:TILE_LOG2]};
            s1_q.de     <= I_de;
            s1_q.fx     <= ex[TILE_LOG2-1:0];
            s1_q.fy     <= ey[TILE_LOG2-1:0];

            O_pat_addr  <= {I_map_data[TILE_IDX_W-1:0], s1_q.fy};
            s2_q.de     <= s1_q.de;
            s2_q.fx     <= s1_q.fx;
            s2_q.bank   <= I_map_data[13:10];
            s2_q.hflip  <= I_map_data[14];
            s2_q.hide   <= hide_now;

            s3_q.de     <= s2_q.de;
            s3_q.transp <= s2_q.hide | (ci == '0);
            s3_q.idx    <= {s2_q.bank, ci};
        end
    end

    // Read-before-write: a lookup on the write edge still returns the old colour.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal[i] <= '0;
            end
        end else if (I_pal_we) begin
            pal[I_pal_addr] <= I_pal_data;
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_pixel  <= '0;
            O_opaque <= 1'b0;
            O_de     <= 1'b0;
        end else begin
            O_de <= s3_q.de;
            if (!s3_q.de) begin
                O_pixel  <= '0;
                O_opaque <= 1'b0;
            end else if (s3_q.transp) begin
                O_pixel  <= DEFAULT_COLOR;
                O_opaque <= 1'b0;
            end else begin
                O_pixel  <= pal[s3_q.idx];
                O_opaque <= 1'b1;
            end
        end
    end

    // Coordinate high bits beyond the map span and spare map-entry bits are don't-care.
    assign unused_bits = ^{I_x, I_y, I_map_data};

endmodule

// File: tb/tb_foreground_tile_plane.sv
// Scoreboarded bench for foreground_tile_plane: randomized pixels, scroll and palette traffic against a reference model.
module tb_foreground_tile_plane;
    localparam int MAP_COLS = 128;
    localparam int EX_MOD   = 1024;
    localparam int EY_MOD   = 512;
    localparam logic [23:0] DEF_COL = 24'h3F5F7F;

    logic        I_pxl_clk = 1'b0;
    logic        I_rst_n   = 1'b0;
    logic        I_de      = 1'b0;
    logic        I_vs      = 1'b0;
    logic [10:0] I_x       = '0;
    logic [9:0]  I_y       = '0;
    logic [9:0]  I_scroll_x = '0;
    logic [8:0]  I_scroll_y = '0;
    logic [12:0] O_map_addr;
    logic [15:0] I_map_data;
    logic [12:0] O_pat_addr;
    logic [31:0] I_pat_data;
    logic        I_pal_we   = 1'b0;
    logic [7:0]  I_pal_addr = '0;
    logic [23:0] I_pal_data = '0;
    logic [23:0] O_pixel;
    logic        O_opaque;
    logic        O_de;

    logic [15:0] map_mem [8192];
    logic [31:0] pat_mem [8192];

    assign I_map_data = map_mem[O_map_addr];
    assign I_pat_data = pat_mem[O_pat_addr];

    foreground_tile_plane dut (
        .I_pxl_clk  (I_pxl_clk),
        .I_rst_n    (I_rst_n),
        .I_de       (I_de),
        .I_vs       (I_vs),
        .I_x        (I_x),
        .I_y        (I_y),
        .I_scroll_x (I_scroll_x),
        .I_scroll_y (I_scroll_y),
        .O_map_addr (O_map_addr),
        .I_map_data (I_map_data),
        .O_pat_addr (O_pat_addr),
        .I_pat_data (I_pat_data),
        .I_pal_we   (I_pal_we),
        .I_pal_addr (I_pal_addr),
        .I_pal_data (I_pal_data),
        .O_pixel    (O_pixel),
        .O_opaque   (O_opaque),
        .O_de       (O_de)
    );

    always #5 I_pxl_clk = ~I_pxl_clk;

    typedef struct {
        int due;
        bit transp;
        int idx;
    } exp_t;

    typedef struct {
        int          edge_n;
        int          idx;
        logic [23:0] data;
    } wr_t;

    exp_t sbq[$];
    wr_t  wlog[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   sx_m = 0;
    int   sy_m = 0;
    int   fcnt = 0;

    always @(posedge I_pxl_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Palette contents seen by a lookup on edge 'due': last write taking effect strictly before it.
    function automatic logic [23:0] pal_at(input int idx, input int due);
        logic [23:0] c = '0;
        foreach (wlog[i]) begin
            if (wlog[i].idx == idx && wlog[i].edge_n < due) c = wlog[i].data;
        end
        return c;
    endfunction

    always @(negedge I_pxl_clk) begin
        if (mon_en) begin
            if (O_de) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_de", 32'(O_de), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("pixel", 32'(O_pixel), 32'(e.transp ? DEF_COL : pal_at(e.idx, e.due)));
                    chk("opaque", 32'(O_opaque), 32'(!e.transp));
                end
            end else begin
                chk("blank", {7'd0, O_opaque, O_pixel}, 32'd0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    void'(sbq.pop_front());
                    chk("missing_de", 32'(O_de), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge I_pxl_clk);
        #1;
    endtask

    task automatic px(input bit de, input int x, input int y);
        I_de = de;
        I_x  = 11'(x);
        I_y  = 10'(y);
        if (de && I_rst_n) begin
            int ex, ey, e, tile, bank, fx, fy, p, ci;
            bit transp;
            logic [31:0] row;
            exp_t n;
            ex   = (x + sx_m) % EX_MOD;
            ey   = (y + sy_m) % EY_MOD;
            fx   = ex % 8;
            fy   = ey % 8;
            e    = int'(map_mem[(ey / 8) * MAP_COLS + ex / 8]);
            tile = e % 1024;
            bank = (e / 1024) % 16;
            p    = ((e / 16384) % 2 == 1) ? 7 - fx : fx;
            row  = pat_mem[tile * 8 + fy];
            ci   = int'((row >> (p * 4)) & 32'hF);
            transp = (ci == 0);
`ifdef FOREGROUND_BLINK_EN
            if (e / 32768 == 1 && fcnt >= 32) transp = 1'b1;
`endif
            n.due = cyc + 4;
            n.transp = transp;
            n.idx = bank * 16 + ci;
            sbq.push_back(n);
        end
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 0, 0);
    endtask

    task automatic set_pal(input int idx, input logic [23:0] data);
        wr_t w;
        I_pal_we   = 1'b1;
        I_pal_addr = 8'(idx);
        I_pal_data = data;
        w.edge_n = cyc + 1;
        w.idx = idx;
        w.data = data;
        wlog.push_back(w);
    endtask

    task automatic pal_wr(input int idx, input logic [23:0] data);
        set_pal(idx, data);
        idle(1);
        I_pal_we = 1'b0;
    endtask

    task automatic frame(input int sx, input int sy);
        idle(3);
        I_scroll_x = 10'(sx);
        I_scroll_y = 9'(sy);
        I_vs = 1'b1;
        sx_m = sx;
        sy_m = sy;
        fcnt = (fcnt + 1) % 64;
        idle(3);
        I_vs = 1'b0;
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            map_mem[i] = 16'($urandom);
            pat_mem[i] = $urandom;
        end
        tick();
        mon_en = 1'b1;
        idle(2);
        I_rst_n = 1'b1;
        idle(6);

        // Palette still at reset: visible pixels are black, index 0 is transparent.
        map_mem[0]  = 16'h0803;
        pat_mem[24] = 32'h0000_0050;
        px(1'b1, 1, 0);
        px(1'b1, 0, 0);
        idle(5);
        pal_wr(8'h25, 24'hFF0000);
        idle(2);
        px(1'b1, 1, 0);
        px(1'b1, 0, 0);
        idle(5);
        map_mem[0] = 16'h4803;
        px(1'b1, 6, 0);
        px(1'b1, 1, 0);
        idle(5);

        // Palette write landing on the E4 edge of the first pixel.
        map_mem[0] = 16'h0803;
        px(1'b1, 1, 0);
        px(1'b1, 1, 0);
        idle(1);
        set_pal(8'h25, 24'h00FF00);
        idle(1);
        I_pal_we = 1'b0;
        idle(5);

        // Scroll wrap, then a mid-frame scroll change that must be ignored.
        frame(1020, 0);
        px(1'b1, 5, 0);
        idle(4);
        I_scroll_x = 10'd0;
        px(1'b1, 5, 0);
        px(1'b1, 4, 0);
        idle(5);

        for (int i = 0; i < 256; i++) pal_wr(i, 24'($urandom));

        for (int f = 0; f < 70; f++) begin
            frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 3) == 0) set_pal(int'($urandom_range(0, 255)), 24'($urandom));
                px($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
                I_pal_we = 1'b0;
            end
        end
        idle(6);

        // Reset mid-frame with pixels in flight.
        for (int j = 0; j < 3; j++) px(1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
        I_rst_n = 1'b0;
        sbq.delete();
        wlog.delete();
        sx_m = 0;
        sy_m = 0;
        fcnt = 0;
        px(1'b1, 3, 3);
        px(1'b1, 4, 4);
        idle(2);
        I_rst_n = 1'b1;
        for (int j = 0; j < 5; j++) px(1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
        idle(8);

        chk("drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
